// File: rtl/tdc_pkg.sv
// Shared types and sizing helpers for the TDC hit stamper.
// Record layout: {sat, coarse, fine}.
package tdc_pkg;

    localparam int LOST_W = 16;

    typedef enum logic [1:0] {
        ARMED    = 2'd0,
        DEAD     = 2'd1,
        WAIT_LOW = 2'd2
    } tdc_state_e;

    function automatic int fine_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int rec_w(input int n, input int coarse_w);
        return 1 + coarse_w + $clog2(n + 1);
    endfunction

endpackage

// File: rtl/tdc_therm_popcount.sv
// Combinational population count of a sampled thermometer code.
// Counting ones rather than finding the top bit makes isolated bubbles harmless.
module tdc_therm_popcount #(
    parameter int N = 16,
    parameter int W = $clog2(N + 1)
) (
    input  logic [N-1:0] therm,
    output logic [W-1:0] count
);

    // sum of all set stages
    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + W'(therm[i]);
        end
    end

endmodule

// File: rtl/tdc_hit_stamper.sv
// Carry-chain TDC back-end: edge detect, popcount fine time, coarse stamp,
// dead time and a small record FIFO with loss counting.
module tdc_hit_stamper
    import tdc_pkg::*;
#(
    parameter int N          = 16,
    parameter int COARSE_W   = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int DEAD_CYC   = 4,
    localparam int FINE_W    = fine_w(N),
    localparam int REC_W     = rec_w(N, COARSE_W)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              ena,
    input  logic [N-1:0]      therm,
    output logic [REC_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LOST_W-1:0] lost_cnt,
    output logic              busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = (DEAD_CYC > 0) ? $clog2(DEAD_CYC + 1) : 1;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [COARSE_W-1:0] coarse;
    logic [COARSE_W-1:0] coarse_q;
    logic [COARSE_W-1:0] s2_coarse;
    logic [N-1:0]        therm_q;
    logic [N-1:0]        s2_therm;
    logic                prev_zero;
    logic                therm_zero;
    logic                hit1;
    logic                s2_valid;
    logic                s3_valid;
    logic [REC_W-1:0]    s3_rec;
    logic [FINE_W-1:0]   fine;

    tdc_state_e          state;
    tdc_state_e          state_nx;
    logic [DW-1:0]       dead_cnt;
    logic [DW-1:0]       dead_cnt_nx;

    logic [REC_W-1:0]    mem [FIFO_DEPTH];
    logic [AW:0]         wr_ptr;
    logic [AW:0]         rd_ptr;
    logic                fifo_empty;
    logic                fifo_full;
    logic                do_pop;
    logic                do_push;
    logic                drop;

    assign therm_zero = (therm_q == '0);
    assign hit1       = !therm_zero && prev_zero && ena && (state == ARMED);

    // S1: sample chain and coarse time together so the stamp matches the sample
    always_ff @(posedge clk) begin
        if (clr) begin
            coarse    <= '0;
            coarse_q  <= '0;
            therm_q   <= '0;
            prev_zero <= 1'b0;
        end else begin
            coarse    <= coarse + COARSE_W'(1);
            coarse_q  <= coarse;
            therm_q   <= therm;
            prev_zero <= therm_zero;
        end
    end

    tdc_therm_popcount #(.N(N), .W(FINE_W)) u_popcount (
        .therm (s2_therm),
        .count (fine)
    );

    // S2 holds the hit sample, S3 holds the finished record awaiting push
    always_ff @(posedge clk) begin
        if (clr) begin
            s2_valid  <= 1'b0;
            s2_therm  <= '0;
            s2_coarse <= '0;
            s3_valid  <= 1'b0;
            s3_rec    <= '0;
        end else begin
            s2_valid  <= hit1;
            s2_therm  <= therm_q;
            s2_coarse <= coarse_q;
            s3_valid  <= s2_valid;
            s3_rec    <= {&s2_therm, s2_coarse, fine};
        end
    end

    // lockout FSM state register
    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= ARMED;
            dead_cnt <= '0;
        end else begin
            state    <= state_nx;
            dead_cnt <= dead_cnt_nx;
        end
    end

    // lockout FSM next state: dead time first, then wait for the chain to clear
    always_comb begin
        state_nx    = state;
        dead_cnt_nx = dead_cnt;
        case (state)
            ARMED: begin
                if (hit1) begin
                    if (DEAD_CYC == 0) begin
                        state_nx = WAIT_LOW;
                    end else begin
                        state_nx    = DEAD;
                        dead_cnt_nx = DW'(DEAD_CYC);
                    end
                end else begin
                    state_nx = ARMED;
                end
            end
            DEAD: begin
                if (dead_cnt <= DW'(1)) begin
                    state_nx    = WAIT_LOW;
                    dead_cnt_nx = '0;
                end else begin
                    dead_cnt_nx = dead_cnt - DW'(1);
                end
            end
            WAIT_LOW: begin
                if (therm_zero) begin
                    state_nx = ARMED;
                end else begin
                    state_nx = WAIT_LOW;
                end
            end
            default: begin
                state_nx    = ARMED;
                dead_cnt_nx = '0;
            end
        endcase
    end

    assign busy = (state != ARMED);

    // extra pointer bit distinguishes full from empty
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop     = !fifo_empty && out_ready;
    assign do_push    = s3_valid && (!fifo_full || do_pop);
    assign drop       = s3_valid && fifo_full && !do_pop;

    // FIFO pointers and saturating loss counter
    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            lost_cnt <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (drop && (lost_cnt != {LOST_W{1'b1}})) begin
                lost_cnt <= lost_cnt + LOST_W'(1);
            end
        end
    end

    // record storage; contents are meaningless once the pointers are cleared
    always_ff @(posedge clk) begin
        if (!clr && do_push) begin
            mem[wr_ptr[AW-1:0]] <= s3_rec;
        end
    end

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_tdc_hit_stamper.sv
// Bench for tdc_hit_stamper: directed cases then randomized traffic against a
// queue-based model of accepted hits, record FIFO and loss count.
module tb_tdc_hit_stamper;

    localparam int N          = 16;
    localparam int COARSE_W   = 16;
    localparam int FIFO_DEPTH = 8;
    localparam int DEAD_CYC   = 4;
    localparam int FINE_W     = $clog2(N + 1);
    localparam int REC_W      = 1 + COARSE_W + FINE_W;

    localparam int PV = 0, PD = 1, PL = 2, PB = 3, PF = 4, PS = 5, PP = 6;

    logic             clk = 1'b0;
    logic             clr = 1'b1;
    logic             ena = 1'b0;
    logic [N-1:0]     therm = '0;
    logic [REC_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [15:0]      lost_cnt;
    logic             busy;

    tdc_hit_stamper #(
        .N(N), .COARSE_W(COARSE_W), .FIFO_DEPTH(FIFO_DEPTH), .DEAD_CYC(DEAD_CYC)
    ) dut (
        .clk(clk), .clr(clr), .ena(ena), .therm(therm),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .lost_cnt(lost_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int               edge_no;
        logic [REC_W-1:0] rec;
    } pend_t;

    logic [REC_W-1:0] m_fifo [$];
    pend_t            m_pend [$];
    int               cyc = 0;
    int               m_lost = 0;
    int               m_cnt = 0;
    int               m_cq = 0;
    logic [N-1:0]     m_tq = '0;
    logic [N-1:0]     m_tq_prev = '0;
    bit               m_locked = 1'b0;
    int               m_wait_from = 0;
    bit               m_ok = 1'b0;
    bit               clr_d = 1'b1;
    bit               rdy_d = 1'b0;
    logic [N-1:0]     therm_d = '0;

    bit               exp_valid = 1'b0;
    bit               exp_busy = 1'b0;
    logic [REC_W-1:0] exp_data = '0;
    int               exp_lost = 0;

    int               pin_cyc = -1;
    int               pin_n = 0;
    int               pin_sel [8];
    logic [31:0]      pin_exp [8];
    string            pin_nm  [8];
    int               pops = 0;

    function automatic logic [N-1:0] therm_code(input int len);
        logic [31:0] v;
        v = (32'd1 << len) - 32'd1;
        return v[N-1:0];
    endfunction

    // Model effect of the clock edge that just occurred
    task automatic model_edge();
        pend_t p;
        if (clr_d) begin
            m_fifo.delete();
            m_pend.delete();
            m_lost = 0; m_cnt = 0; m_cq = 0;
            m_tq = '0; m_tq_prev = '0;
            m_locked = 1'b0;
            m_ok = 1'b1;
        end else if (m_ok) begin
            if (m_fifo.size() > 0 && rdy_d) void'(m_fifo.pop_front());
            while (m_pend.size() > 0 && m_pend[0].edge_no == cyc) begin
                p = m_pend.pop_front();
                if (m_fifo.size() < FIFO_DEPTH) m_fifo.push_back(p.rec);
                else if (m_lost < 65535) m_lost++;
            end
            m_cq  = m_cnt;
            m_cnt = (m_cnt + 1) % 65536;
            m_tq_prev = m_tq;
            m_tq      = therm_d;
        end
    endtask

    // A hit is a zero->nonzero sample while unlocked; record lands in FIFO 3 edges later
    task automatic model_hit(input bit e);
        pend_t p;
        logic [COARSE_W-1:0] cq;
        logic [FINE_W-1:0]   f;
        if (!m_locked && e && m_tq != '0 && m_tq_prev == '0) begin
            cq = COARSE_W'(m_cq);
            f  = FINE_W'($countones(m_tq));
            p.edge_no = cyc + 3;
            p.rec     = {&m_tq, cq, f};
            m_pend.push_back(p);
            m_locked    = 1'b1;
            m_wait_from = cyc + DEAD_CYC + 1;
        end else if (m_locked && cyc >= m_wait_from && m_tq == '0) begin
            m_locked = 1'b0;
        end
    endtask

    task automatic step(input bit c, input bit e, input logic [N-1:0] t, input bit r);
        @(posedge clk);
        #1;
        cyc++;
        model_edge();
        exp_valid = (m_fifo.size() > 0);
        exp_data  = exp_valid ? m_fifo[0] : '0;
        exp_lost  = m_lost;
        exp_busy  = m_locked;
        clr = c; ena = e; therm = t; out_ready = r;
        clr_d = c; rdy_d = r; therm_d = t;
        model_hit(e);
    endtask

    task automatic add_pin(input int sel, input logic [31:0] e, input string nm);
        if (pin_cyc != cyc) begin
            pin_cyc = cyc;
            pin_n   = 0;
        end
        pin_sel[pin_n] = sel;
        pin_exp[pin_n] = e;
        pin_nm[pin_n]  = nm;
        pin_n++;
    endtask

    function automatic logic [31:0] pin_actual(input int sel);
        case (sel)
            PV:      return 32'(out_valid);
            PD:      return 32'(out_data);
            PL:      return 32'(lost_cnt);
            PB:      return 32'(busy);
            PF:      return 32'(out_data[FINE_W-1:0]);
            PS:      return 32'(out_data[REC_W-1]);
            default: return 32'(pops);
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] e);
        n_checks++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, e);
        end
    endtask

    // Compare process: model every cycle plus any literal pins for this cycle
    always @(negedge clk) begin
        if (m_ok) begin
            chk("out_valid", 32'(out_valid), 32'(exp_valid));
            chk("lost_cnt", 32'(lost_cnt), 32'(exp_lost));
            chk("busy", 32'(busy), 32'(exp_busy));
            if (exp_valid) chk("out_data", 32'(out_data), 32'(exp_data));
            if (pin_cyc == cyc) begin
                for (int i = 0; i < pin_n; i++) chk(pin_nm[i], pin_actual(pin_sel[i]), pin_exp[i]);
            end
        end
    end

    initial begin
        logic [N-1:0] cur;
        bit           rdy;
        int           r;
        int           k;

        // reset, then idle with coarse running 0..99
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, '0, 1'b1);
        add_pin(PV, 32'd0, "rst_valid");
        add_pin(PL, 32'd0, "rst_lost");
        add_pin(PB, 32'd0, "rst_busy");
        add_pin(PD, 32'd0, "rst_data");
        for (int i = 1; i < 100; i++) step(1'b0, 1'b1, '0, 1'b1);
        add_pin(PV, 32'd0, "idle_valid");
        add_pin(PB, 32'd0, "idle_busy");

        // single hit at coarse 100
        step(1'b0, 1'b1, 16'h003F, 1'b0);
        repeat (3) step(1'b0, 1'b1, '0, 1'b0);
        add_pin(PV, 32'd0, "latency_early");
        step(1'b0, 1'b1, '0, 1'b0);
        add_pin(PV, 32'd1, "latency_valid");
        add_pin(PD, 32'({1'b0, 16'd100, 5'd6}), "rec_c100");
        repeat (10) step(1'b0, 1'b1, '0, 1'b1);

        // saturated chain and bubble code
        step(1'b0, 1'b1, 16'hFFFF, 1'b0);
        repeat (4) step(1'b0, 1'b1, '0, 1'b0);
        add_pin(PS, 32'd1, "sat_flag");
        add_pin(PF, 32'd16, "sat_fine");
        repeat (10) step(1'b0, 1'b1, '0, 1'b1);
        step(1'b0, 1'b1, 16'h00BF, 1'b0);
        repeat (4) step(1'b0, 1'b1, '0, 1'b0);
        add_pin(PS, 32'd0, "bubble_sat");
        add_pin(PF, 32'd7, "bubble_fine");
        repeat (10) step(1'b0, 1'b1, '0, 1'b1);

        // dead time and wait-for-low
        step(1'b0, 1'b1, 16'h000F, 1'b0);
        step(1'b0, 1'b1, '0, 1'b0);
        repeat (13) step(1'b0, 1'b1, 16'h000F, 1'b0);
        add_pin(PB, 32'd1, "hold_busy");
        repeat (8) step(1'b0, 1'b1, '0, 1'b0);
        add_pin(PV, 32'd1, "dead_first_rec");
        add_pin(PB, 32'd0, "dead_rearmed");
        step(1'b0, 1'b1, '0, 1'b1);
        step(1'b0, 1'b1, '0, 1'b0);
        add_pin(PV, 32'd0, "dead_only_one");

        // overflow: 10 hits into an 8-deep FIFO with no readout
        for (int h = 0; h < 10; h++) begin
            step(1'b0, 1'b1, therm_code(h + 1), 1'b0);
            repeat (7) step(1'b0, 1'b1, '0, 1'b0);
        end
        repeat (4) step(1'b0, 1'b1, '0, 1'b0);
        add_pin(PL, 32'd2, "ovf_lost");
        add_pin(PV, 32'd1, "ovf_valid");
        pops = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, '0, 1'b1);
            if (out_valid) pops++;
        end
        add_pin(PP, 32'd8, "ovf_drained");
        add_pin(PV, 32'd0, "ovf_empty");

        // clr with 3 buffered records and one in flight
        for (int h = 0; h < 3; h++) begin
            step(1'b0, 1'b1, 16'h0003, 1'b0);
            repeat (7) step(1'b0, 1'b1, '0, 1'b0);
        end
        step(1'b0, 1'b1, 16'h0007, 1'b0);
        step(1'b0, 1'b1, '0, 1'b0);
        step(1'b1, 1'b1, '0, 1'b0);
        step(1'b0, 1'b1, '0, 1'b1);
        add_pin(PV, 32'd0, "clr_valid");
        add_pin(PL, 32'd0, "clr_lost");
        add_pin(PB, 32'd0, "clr_busy");
        repeat (10) step(1'b0, 1'b1, '0, 1'b1);
        add_pin(PV, 32'd0, "clr_no_stale");

        // randomized traffic
        cur = '0;
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 30) begin
                k = $urandom_range(0, 9);
                if (k < 5) cur = '0;
                else if (k < 9) cur = therm_code($urandom_range(1, 16));
                else cur = N'($urandom);
            end
            if (((i / 300) % 3) == 1) rdy = ($urandom_range(0, 9) == 0);
            else rdy = ($urandom_range(0, 3) != 0);
            step(($urandom_range(0, 999) == 0), ($urandom_range(0, 9) != 0), cur, rdy);
        end
        repeat (20) step(1'b0, 1'b1, '0, 1'b1);
        @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
